// File: rtl/qoi332_pkg.sv
// Shared definitions for the RGB332 run/index/diff codec: opcodes, biases,
// decoder states and the index hash used by both encoder and decoder.
package qoi332_pkg;

    localparam logic [7:0] OP_RAW = 8'hFE;
    localparam logic [7:0] OP_END = 8'hFF;

    localparam logic [1:0] TAG_INDEX = 2'b00;
    localparam logic [1:0] TAG_DIFF  = 2'b01;
    localparam logic [1:0] TAG_LUMA  = 2'b10;
    localparam logic [1:0] TAG_RUN   = 2'b11;

    localparam int DIFF_BIAS    = 2;
    localparam int LUMA_G_BIAS  = 32;
    localparam int LUMA_RB_BIAS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RD_OP,
        S_OP,
        S_ARG,
        S_RUN,
        S_DONE
    } state_t;

    // (r*3 + g*5 + b*7) mod 64, carried out directly in 6 bits
    function automatic logic [5:0] qoi_hash(input logic [7:0] px);
        return {3'b0, px[7:5]} * 6'd3 + {3'b0, px[4:2]} * 6'd5 + {4'b0, px[1:0]} * 6'd7;
    endfunction

endpackage

// File: rtl/qoi332_index_table.sv
// Recently-seen pixel table: combinational read, one synchronous write port
// shared between the bulk clear sweep and the per-pixel hash update.
module qoi332_index_table
    import qoi332_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [IDX_BITS-1:0] clear_idx,
    input  logic                upd,
    input  logic [7:0]          upd_px,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [7:0]          rd_px
);

    logic [7:0]          mem [2**IDX_BITS];
    logic                we;
    logic [IDX_BITS-1:0] widx;
    logic [7:0]          wdat;

    always_comb begin
        we   = clear | upd;
        widx = clear ? clear_idx : IDX_BITS'(qoi_hash(upd_px));
        wdat = clear ? 8'h00 : upd_px;
    end

    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdat;
    end

    assign rd_px = mem[rd_idx];

endmodule

// File: rtl/qoi332_decoder.sv
// Streams encoded bytes out of the source BRAM and writes decoded RGB332
// pixels sequentially into the frame buffer.
module qoi332_decoder
    import qoi332_pkg::*;
#(
    parameter int NUM_PIXELS   = 307200,
    parameter int ADDR_W       = 19,
    parameter int MAX_IN_BYTES = 307200,
    parameter int IDX_BITS     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic [7:0]        wr_data,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   MAX_L = (ADDR_W+1)'(MAX_IN_BYTES);
    localparam logic [ADDR_W:0]   NUM_L = (ADDR_W+1)'(NUM_PIXELS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_PIXELS - 1);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr_q, count;
    logic [7:0]          prev, op_q;
    logic [5:0]          run_cnt;
    logic [IDX_BITS-1:0] clr_idx;

    logic                emit, set_err;
    logic [7:0]          emit_px, idx_px, diff_px, luma_px;
    logic [1:0]          tag;
    logic [ADDR_W:0]     addr_ext, addr_p1;
    logic [6:0]          luma_dg;

    assign tag      = rd_data[7:6];
    assign addr_ext = {1'b0, addr_q};
    assign addr_p1  = addr_ext + 1'b1;
    assign done     = (state == S_DONE);

    assign diff_px = {prev[7:5] + {1'b0, rd_data[5:4]} - 3'(DIFF_BIAS),
                      prev[4:2] + {1'b0, rd_data[3:2]} - 3'(DIFF_BIAS),
                      prev[1:0] + rd_data[1:0]         - 2'(DIFF_BIAS)};

    // op_q holds the LUMA opcode while rd_data carries its argument byte
    assign luma_dg = {1'b0, op_q[5:0]} - 7'(LUMA_G_BIAS);
    assign luma_px = {prev[7:5] + 3'({3'b0, rd_data[7:4]} - 7'(LUMA_RB_BIAS) + luma_dg),
                      prev[4:2] + luma_dg[2:0],
                      prev[1:0] + 2'({3'b0, rd_data[3:0]} - 7'(LUMA_RB_BIAS) + luma_dg)};

    qoi332_index_table #(.IDX_BITS(IDX_BITS)) u_table (
        .clk       (clk),
        .clear     (state == S_CLEAR),
        .clear_idx (clr_idx),
        .upd       (emit),
        .upd_px    (emit_px),
        .rd_idx    (rd_data[IDX_BITS-1:0]),
        .rd_px     (idx_px)
    );

    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        emit_px  = prev;
        rd_en    = 1'b0;
        rd_addr  = addr_q;
        set_err  = 1'b0;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_CLEAR;
            S_CLEAR: if (&clr_idx) state_nx = S_RD_OP;
            S_RD_OP: begin
                if (addr_ext >= MAX_L) begin
                    set_err  = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    rd_en    = 1'b1;
                    state_nx = S_OP;
                end
            end
            S_OP: begin
                if (rd_data == OP_END) begin
                    set_err  = ({1'b0, count} < NUM_L);
                    state_nx = S_DONE;
                end else if (rd_data == OP_RAW || tag == TAG_LUMA) begin
                    if (addr_p1 >= MAX_L) begin
                        set_err  = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        rd_en    = 1'b1;
                        rd_addr  = addr_p1[ADDR_W-1:0];
                        state_nx = S_ARG;
                    end
                end else begin
                    emit = 1'b1;
                    unique case (tag)
                        TAG_INDEX: emit_px = idx_px;
                        TAG_DIFF:  emit_px = diff_px;
                        default:   emit_px = prev;
                    endcase
                    state_nx = (tag == TAG_RUN && rd_data[5:0] != 6'd0) ? S_RUN : S_RD_OP;
                end
            end
            S_ARG: begin
                emit     = 1'b1;
                emit_px  = (op_q == OP_RAW) ? rd_data : luma_px;
                state_nx = S_RD_OP;
            end
            S_RUN: begin
                emit     = 1'b1;
                state_nx = (run_cnt == 6'd1) ? S_RD_OP : S_RUN;
            end
            S_DONE:  if (start) state_nx = S_CLEAR;
            default: state_nx = S_IDLE;
        endcase
        // the final pixel of the frame ends decoding regardless of what remains
        if (emit && count == LAST) state_nx = S_DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            count   <= '0;
            prev    <= 8'h00;
            op_q    <= 8'h00;
            run_cnt <= 6'd0;
            clr_idx <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            wr_en <= emit;
            if (emit) begin
                wr_addr <= count;
                wr_data <= emit_px;
                count   <= count + 1'b1;
                prev    <= emit_px;
            end
            if (set_err) err <= 1'b1;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr_q  <= '0;
                        count   <= '0;
                        err     <= 1'b0;
                        prev    <= 8'h00;
                        clr_idx <= '0;
                    end
                end
                S_CLEAR: clr_idx <= clr_idx + 1'b1;
                S_OP: begin
                    addr_q <= addr_q + 1'b1;
                    op_q   <= rd_data;
                    if (tag == TAG_RUN) run_cnt <= rd_data[5:0];
                end
                S_ARG:   addr_q  <= addr_q + 1'b1;
                S_RUN:   run_cnt <= run_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qoi332_decoder.sv
// Randomized and directed streams decoded by the DUT and compared against a
// byte-level reference decoder of the stream format.
module tb_qoi332_decoder;

    localparam int NP   = 48;
    localparam int MAXB = 60;
    localparam int AW   = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          rd_en, wr_en, done, err;
    logic [7:0]    rd_data = 8'h00;
    logic [7:0]    wr_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [64];
    logic [7:0] stim [$];
    int         exp_q [$];
    int         got_a [$];
    int         got_d [$];
    int         tbl [64];
    int         pr, pg, pb;
    int         max_rd, oob;

    always #5 clk = ~clk;

    qoi332_decoder #(.NUM_PIXELS(NP), .ADDR_W(AW), .MAX_IN_BYTES(MAXB), .IDX_BITS(6)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
        .done(done), .err(err)
    );

    always @(posedge clk) if (rd_en) rd_data <= (rd_addr < 64) ? mem[rd_addr[5:0]] : 8'hFF;

    always @(negedge clk) begin
        if (wr_en) begin
            got_a.push_back(int'(wr_addr));
            got_d.push_back(int'(wr_data));
        end
        if (rd_en) begin
            if (int'(rd_addr) > max_rd) max_rd = int'(rd_addr);
            if (int'(rd_addr) >= MAXB) oob++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gd(input int i);
        return (i < got_d.size()) ? 32'(got_d[i]) : 32'hDEAD;
    endfunction

    function automatic void emit(input int px);
        int r, g, b;
        r = (px >> 5) & 7;
        g = (px >> 2) & 7;
        b = px & 3;
        exp_q.push_back(px);
        pr = r; pg = g; pb = b;
        tbl[(r * 3 + g * 5 + b * 7) % 64] = px;
    endfunction

    function automatic int pack(input int r, input int g, input int b);
        return ((r & 7) << 5) | ((g & 7) << 2) | (b & 3);
    endfunction

    // Reference decode of mem[]: expected pixels, error flag, highest byte fetched
    task automatic model(output int e, output int last);
        int p, op, b2, dg;
        exp_q.delete();
        for (int i = 0; i < 64; i++) tbl[i] = 0;
        pr = 0; pg = 0; pb = 0;
        e = 0; last = -1; p = 0;
        while (exp_q.size() < NP) begin
            if (p >= MAXB) begin e = 1; break; end
            op = int'(mem[p]); last = p; p++;
            if (op == 'hFF) begin e = (exp_q.size() < NP) ? 1 : 0; break; end
            if (op == 'hFE || (op >> 6) == 2) begin
                if (p >= MAXB) begin e = 1; break; end
                b2 = int'(mem[p]); last = p; p++;
                if (op == 'hFE) emit(b2);
                else begin
                    dg = (op & 63) - 32;
                    emit(pack(pr + (b2 >> 4) - 8 + dg, pg + dg, pb + (b2 & 15) - 8 + dg));
                end
            end else if ((op >> 6) == 3) begin
                for (int k = 0; k <= (op & 63) && exp_q.size() < NP; k++) emit(pack(pr, pg, pb));
            end else if ((op >> 6) == 0) begin
                emit(tbl[op & 63]);
            end else begin
                emit(pack(pr + ((op >> 4) & 3) - 2, pg + ((op >> 2) & 3) - 2, pb + (op & 3) - 2));
            end
        end
    endtask

    task automatic load_stim();
        for (int i = 0; i < 64; i++) mem[i] = (i < stim.size()) ? stim[i] : 8'hFF;
    endtask

    task automatic run_frame(input string tag);
        int e_err, e_last, c, n;
        load_stim();
        model(e_err, e_last);
        got_a.delete(); got_d.delete();
        max_rd = -1; oob = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (!rd_en && c < 200) begin @(negedge clk); c++; end
        chk({tag, ":first_rd"}, c, 65);
        c = 0;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        chk({tag, ":done"}, done, 1'b1);
        repeat (3) @(negedge clk);
        chk({tag, ":done_hold"}, done, 1'b1);
        chk({tag, ":npix"}, got_d.size(), exp_q.size());
        n = (got_d.size() < exp_q.size()) ? got_d.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s:addr%0d", tag, i), got_a[i], i);
            chk($sformatf("%s:px%0d", tag, i), got_d[i], exp_q[i]);
        end
        chk({tag, ":err"}, err, e_err[0]);
        chk({tag, ":max_rd"}, max_rd, e_last);
        chk({tag, ":oob"}, oob, 0);
    endtask

    task automatic gen_random();
        int kind;
        stim.delete();
        while (stim.size() < 64) begin
            kind = $urandom_range(0, 19);
            if (kind < 3) begin
                stim.push_back(8'hFE); stim.push_back(8'($urandom));
            end else if (kind < 6) begin
                stim.push_back(8'hC0 | 8'($urandom_range(0, 61)));
            end else if (kind < 10) begin
                stim.push_back(8'($urandom_range(0, 63)));
            end else if (kind < 14) begin
                stim.push_back(8'h40 | 8'($urandom_range(0, 63)));
            end else if (kind < 18) begin
                stim.push_back(8'h80 | 8'($urandom_range(0, 63))); stim.push_back(8'($urandom));
            end else if (kind == 18) begin
                stim.push_back(8'h00 | 8'($urandom_range(0, 63)));
            end else begin
                stim.push_back(8'hFF);
            end
        end
    endtask

    initial begin
        #1;
        chk("rst:rd_addr", rd_addr, 0);
        chk("rst:rd_en", rd_en, 0);
        chk("rst:wr_addr", wr_addr, 0);
        chk("rst:wr_en", wr_en, 0);
        chk("rst:wr_data", wr_data, 0);
        chk("rst:done", done, 0);
        chk("rst:err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        stim = '{8'hFE, 8'hA5, 8'hC2, 8'hF9};
        run_frame("raw_run");
        chk("raw_run:last_px", gd(NP - 1), 8'hA5);
        chk("raw_run:err_c", err, 1'b0);

        stim = '{8'h7B, 8'h4A, 8'hFF};
        run_frame("diff");
        chk("diff:c0", gd(0), 8'h21);
        chk("diff:c1", gd(1), 8'hE1);

        stim = '{8'hA1, 8'h88, 8'hFF};
        run_frame("luma");
        chk("luma:c0", gd(0), 8'h25);

        stim = '{8'hFE, 8'hA5, 8'h1B, 8'hFF};
        run_frame("index");
        chk("index:c1", gd(1), 8'hA5);
        stim = '{8'h1B, 8'hFF};
        run_frame("index_clr");
        chk("index_clr:c0", gd(0), 8'h00);

        stim = '{8'hFE, 8'h10, 8'hFF};
        run_frame("early_end");
        chk("early_end:n", got_d.size(), 1);
        chk("early_end:err_c", err, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart:err_clr", err, 1'b0);
        chk("restart:busy", done, 1'b0);
        repeat (80) @(negedge clk);

        stim.delete();
        for (int i = 0; i < 32; i++) begin stim.push_back(8'hFE); stim.push_back(8'(i * 7)); end
        run_frame("max_op");
        stim.delete();
        stim.push_back(8'h6A);
        for (int i = 0; i < 32; i++) begin stim.push_back(8'hFE); stim.push_back(8'(i * 3)); end
        run_frame("max_arg");

        stim = '{8'hFE, 8'h37, 8'hE7, 8'hE7, 8'hFF};
        load_stim();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 500 && got_d.size() < 12; c++) @(negedge clk);
        chk("midrst:reached", got_d.size() >= 12, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst:rd_en", rd_en, 0);
        chk("midrst:rd_addr", rd_addr, 0);
        chk("midrst:wr_en", wr_en, 0);
        chk("midrst:wr_addr", wr_addr, 0);
        chk("midrst:wr_data", wr_data, 0);
        chk("midrst:done", done, 0);
        chk("midrst:err", err, 0);
        got_d.delete(); got_a.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst:no_wr", got_d.size(), 0);
        chk("midrst:idle", done, 0);
        run_frame("after_rst");

        for (int f = 0; f < 30; f++) begin
            gen_random();
            run_frame($sformatf("rand%0d", f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
